// File: rtl/piso16_unchain32.sv
// rtl/piso16_unchain32.sv - parallel-in/serial-out frame unloader on a valid/ready stream
//
// Captures DEPTH words of WIDTH bits in one cycle, then emits them word 0 first,
// one word per accepted beat.
//
// Parameters:
//   WIDTH  bits per word
//   DEPTH  words per frame (2..32)
//   CW     counter width, ceil(log2(DEPTH))
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   load_valid  parallel frame present on din_all
//   load_ready  idle and able to accept a frame (0 while rst=1)
//   din_all     frame; word k is din_all[WIDTH*k +: WIDTH]
//   dout_valid  dout holds a valid word
//   dout_ready  downstream accepts dout this cycle
//   dout        current serial word, 0 when dout_valid=0
//   frame_done  one-cycle pulse on the cycle after the last word is accepted
//   busy        frame in flight
//   dout_last   (only with PISO16_LAST_FLAG_EN) dout is the last word of the frame
//
// Optional feature macro: PISO16_LAST_FLAG_EN

module piso16_unchain32 #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32,
    parameter int CW    = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [WIDTH*DEPTH-1:0] din_all,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic [WIDTH-1:0]       dout,
    output logic                   frame_done,
    output logic                   busy
`ifdef PISO16_LAST_FLAG_EN
    ,
    output logic                   dout_last
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] buf_q [DEPTH];
    logic             frame_done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            frame_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            buf_q[i] <= din_all[WIDTH*i +: WIDTH];
                        end
                        cnt   <= '0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    // dout_valid is implied by SEND, so ready alone completes a beat
                    if (dout_ready) begin
                        for (int i = 0; i < DEPTH - 1; i++) begin
                            buf_q[i] <= buf_q[i+1];
                        end
                        buf_q[DEPTH-1] <= '0;
                        if (cnt == LAST_CNT) begin
                            cnt          <= '0;
                            state        <= IDLE;
                            frame_done_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // load_ready is masked by rst so nothing upstream sees a ready during reset
    assign load_ready = ~rst & (state == IDLE);
    assign dout_valid = (state == SEND);
    assign busy       = (state == SEND);
    assign frame_done = frame_done_q;
    assign dout       = dout_valid ? buf_q[0] : '0;

`ifdef PISO16_LAST_FLAG_EN
    assign dout_last  = dout_valid & (cnt == LAST_CNT);
`endif

endmodule
